// File: rtl/rv32_pipeline_pkg.sv
// Shared types and width constants for the RV32 pipeline controller.
package rv32_pipeline_pkg;

   localparam int REG_IDX_W   = 5;
   localparam int STALL_CNT_W = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // FENCE drain sequencing: RUN (normal), DRAIN (hold FENCE in decode), SYNC (release it)
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      SYNC  = 2'd2
   } rv32_fence_state_t;

   // All per-stage control outputs, packed so the priority mux can default them in one go
   typedef struct packed {
      logic fetch_stall;
      logic decode_stall;
      logic execute_stall;
      logic mem_stall;
      logic fetch_flush;
      logic decode_flush;
      logic execute_flush;
      logic mem_flush;
      logic fence;
   } ctrl_out_t;

endpackage

// File: rtl/rv32_pipeline_ctrl_if.sv
// Bundle of pipeline status inputs and stage control outputs of the pipeline controller.
interface rv32_pipeline_ctrl_if;
   import rv32_pipeline_pkg::*;

   logic                   fetch_valid_in;
   reg_idx_t               decode_rs1_in;
   logic                   decode_rs1_read_in;
   reg_idx_t               decode_rs2_in;
   logic                   decode_rs2_read_in;
   logic                   decode_mem_fence_in;
   logic                   execute_valid_in;
   reg_idx_t               execute_rd_in;
   logic                   execute_rd_write_in;
   logic                   execute_mem_read_in;
   logic                   execute_branch_taken_in;
   logic                   mem_valid_in;
   logic                   instr_wait_in;
   logic                   data_wait_in;

   logic                   fetch_stall_out;
   logic                   decode_stall_out;
   logic                   execute_stall_out;
   logic                   mem_stall_out;
   logic                   fetch_flush_out;
   logic                   decode_flush_out;
   logic                   execute_flush_out;
   logic                   mem_flush_out;
   logic                   fence_out;
   logic [STALL_CNT_W-1:0] stall_count_out;

   // Controller side
   modport master (
      input  fetch_valid_in, decode_rs1_in, decode_rs1_read_in, decode_rs2_in,
             decode_rs2_read_in, decode_mem_fence_in, execute_valid_in, execute_rd_in,
             execute_rd_write_in, execute_mem_read_in, execute_branch_taken_in,
             mem_valid_in, instr_wait_in, data_wait_in,
      output fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
             fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out,
             fence_out, stall_count_out
   );

   // Pipeline side
   modport slave (
      output fetch_valid_in, decode_rs1_in, decode_rs1_read_in, decode_rs2_in,
             decode_rs2_read_in, decode_mem_fence_in, execute_valid_in, execute_rd_in,
             execute_rd_write_in, execute_mem_read_in, execute_branch_taken_in,
             mem_valid_in, instr_wait_in, data_wait_in,
      input  fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
             fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out,
             fence_out, stall_count_out
   );

endinterface

// File: rtl/rv32_load_use_detect.sv
// Load-use hazard: a load in execute writes a register that decode is about to read.
module rv32_load_use_detect
   import rv32_pipeline_pkg::*;
(
   input  reg_idx_t rs1,
   input  logic     rs1_read,
   input  reg_idx_t rs2,
   input  logic     rs2_read,
   input  reg_idx_t rd,
   input  logic     rd_write,
   input  logic     mem_read,
   output logic     hazard
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = rs1_read && (rs1 == rd);
   assign rs2_hit = rs2_read && (rs2 == rd);

   // x0 is never really written, so a load targeting it cannot create a dependency
   assign hazard = mem_read && rd_write && (rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/rv32_pipeline_ctrl.sv
// Pipeline controller: per-stage stall/flush priority mux, FENCE drain FSM, stall-cycle counter.
module rv32_pipeline_ctrl
   import rv32_pipeline_pkg::*;
(
   input logic                 clk,
   input logic                 reset,
   rv32_pipeline_ctrl_if.master bus
);

   rv32_fence_state_t       state_q;
   rv32_fence_state_t       state_d;
   ctrl_out_t               ctrl;
   logic                    load_use;
   logic                    fence_hold;
   logic [STALL_CNT_W-1:0]  stall_count_q;

   rv32_load_use_detect u_load_use (
      .rs1      (bus.decode_rs1_in),
      .rs1_read (bus.decode_rs1_read_in),
      .rs2      (bus.decode_rs2_in),
      .rs2_read (bus.decode_rs2_read_in),
      .rd       (bus.execute_rd_in),
      .rd_write (bus.execute_rd_write_in),
      .mem_read (bus.execute_mem_read_in),
      .hazard   (load_use)
   );

   // FENCE is held in decode on the detection cycle and for the whole drain
   assign fence_hold = ((state_q == RUN) && bus.fetch_valid_in && bus.decode_mem_fence_in)
                     || (state_q == DRAIN);

   // FENCE FSM state register
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so all registers sample pre-edge values.
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // FENCE FSM next state: data wait freezes it, a taken branch aborts any FENCE in flight
   always_comb begin
      // NOTE: state_d gets a default before any branch so no path can infer a latch.
      state_d = state_q;
      if (bus.data_wait_in) begin
         state_d = state_q;
      end else if (bus.execute_branch_taken_in) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN:     if (bus.fetch_valid_in && bus.decode_mem_fence_in) state_d = DRAIN;
            DRAIN:   if (!bus.execute_valid_in && !bus.mem_valid_in)    state_d = SYNC;
            SYNC:    state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   // Stall/flush priority mux: the first active source decides all stage controls
   always_comb begin
      ctrl = '0;
      if (reset) begin
         ctrl.fetch_flush   = 1'b1;
         ctrl.decode_flush  = 1'b1;
         ctrl.execute_flush = 1'b1;
         ctrl.mem_flush     = 1'b1;
      end else if (bus.data_wait_in) begin
         ctrl.fetch_stall   = 1'b1;
         ctrl.decode_stall  = 1'b1;
         ctrl.execute_stall = 1'b1;
         ctrl.mem_stall     = 1'b1;
      end else if (bus.execute_branch_taken_in) begin
         ctrl.fetch_flush   = 1'b1;
         ctrl.decode_flush  = 1'b1;
      end else begin
         if (load_use || fence_hold) begin
            ctrl.fetch_stall  = 1'b1;
            ctrl.decode_flush = 1'b1;
         end else if (bus.instr_wait_in) begin
            ctrl.fetch_flush  = 1'b1;
         end
         // FENCE advances into execute in SYNC unless a wait or branch intervened above
         ctrl.fence = (state_q == SYNC);
      end
   end

   // Stall-cycle performance counter, wraps naturally at the counter width
   always_ff @(posedge clk) begin
      if (reset)                 stall_count_q <= '0;
      else if (ctrl.fetch_stall) stall_count_q <= stall_count_q + STALL_CNT_W'(1);
   end

   assign bus.fetch_stall_out   = ctrl.fetch_stall;
   assign bus.decode_stall_out  = ctrl.decode_stall;
   assign bus.execute_stall_out = ctrl.execute_stall;
   assign bus.mem_stall_out     = ctrl.mem_stall;
   assign bus.fetch_flush_out   = ctrl.fetch_flush;
   assign bus.decode_flush_out  = ctrl.decode_flush;
   assign bus.execute_flush_out = ctrl.execute_flush;
   assign bus.mem_flush_out     = ctrl.mem_flush;
   assign bus.fence_out         = ctrl.fence;
   assign bus.stall_count_out   = stall_count_q;

endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// Directed bench for rv32_pipeline_ctrl with a cycle-level reference model and literal spot checks.
module tb_rv32_pipeline_ctrl;
   import rv32_pipeline_pkg::*;

   localparam logic [31:0] PRELOAD = 32'hFFFF_FFFE;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic preload_pending = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   rv32_pipeline_ctrl_if bus ();

   rv32_pipeline_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // fence_waiting: a detected FENCE is being held until execute/memory are empty
   // fence_issuing: the pipeline is empty and the held FENCE goes through this cycle
   logic        fence_waiting = 1'b0;
   logic        fence_issuing = 1'b0;
   logic [31:0] m_count = 32'd0;
   ctrl_out_t   m_exp;

   function automatic ctrl_out_t model_out();
      ctrl_out_t o;
      logic      lu;
      logic      hold;
      o  = '0;
      lu = bus.execute_mem_read_in && bus.execute_rd_write_in && (bus.execute_rd_in != 5'd0)
           && ((bus.decode_rs1_read_in && (bus.decode_rs1_in == bus.execute_rd_in))
            || (bus.decode_rs2_read_in && (bus.decode_rs2_in == bus.execute_rd_in)));
      hold = fence_waiting || (!fence_issuing && bus.fetch_valid_in && bus.decode_mem_fence_in);
      if (reset) begin
         {o.fetch_flush, o.decode_flush, o.execute_flush, o.mem_flush} = 4'b1111;
      end else if (bus.data_wait_in) begin
         {o.fetch_stall, o.decode_stall, o.execute_stall, o.mem_stall} = 4'b1111;
      end else if (bus.execute_branch_taken_in) begin
         o.fetch_flush  = 1'b1;
         o.decode_flush = 1'b1;
      end else begin
         if (lu || hold) begin
            o.fetch_stall  = 1'b1;
            o.decode_flush = 1'b1;
         end else if (bus.instr_wait_in) begin
            o.fetch_flush = 1'b1;
         end
         o.fence = fence_issuing;
      end
      return o;
   endfunction

   always_comb m_exp = model_out();

   always @(posedge clk) begin
      if (reset) begin
         fence_waiting <= 1'b0;
         fence_issuing <= 1'b0;
         m_count       <= 32'd0;
      end else begin
         m_count <= (preload_pending ? PRELOAD : m_count) + {31'd0, m_exp.fetch_stall};
         if (bus.data_wait_in) begin
            fence_waiting <= fence_waiting;
         end else if (bus.execute_branch_taken_in) begin
            fence_waiting <= 1'b0;
            fence_issuing <= 1'b0;
         end else if (fence_issuing) begin
            fence_issuing <= 1'b0;
         end else if (fence_waiting) begin
            if (!bus.execute_valid_in && !bus.mem_valid_in) begin
               fence_waiting <= 1'b0;
               fence_issuing <= 1'b1;
            end
         end else if (bus.fetch_valid_in && bus.decode_mem_fence_in) begin
            fence_waiting <= 1'b1;
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model
   always @(negedge clk) begin
      check("ctrl_outputs",
            {23'd0, bus.fetch_stall_out, bus.decode_stall_out, bus.execute_stall_out,
             bus.mem_stall_out, bus.fetch_flush_out, bus.decode_flush_out,
             bus.execute_flush_out, bus.mem_flush_out, bus.fence_out},
            {23'd0, m_exp});
      check("stall_count", bus.stall_count_out, preload_pending ? PRELOAD : m_count);
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      bus.fetch_valid_in          = 1'b0;
      bus.decode_rs1_in           = 5'd0;
      bus.decode_rs1_read_in      = 1'b0;
      bus.decode_rs2_in           = 5'd0;
      bus.decode_rs2_read_in      = 1'b0;
      bus.decode_mem_fence_in     = 1'b0;
      bus.execute_valid_in        = 1'b0;
      bus.execute_rd_in           = 5'd0;
      bus.execute_rd_write_in     = 1'b0;
      bus.execute_mem_read_in     = 1'b0;
      bus.execute_branch_taken_in = 1'b0;
      bus.mem_valid_in            = 1'b0;
      bus.instr_wait_in           = 1'b0;
      bus.data_wait_in            = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fence_in_decode(input logic occupied);
      idle();
      bus.fetch_valid_in      = 1'b1;
      bus.decode_mem_fence_in = 1'b1;
      bus.execute_valid_in    = occupied;
      bus.mem_valid_in        = occupied;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      idle();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_flushes", {28'd0, bus.fetch_flush_out, bus.decode_flush_out,
                               bus.execute_flush_out, bus.mem_flush_out}, 32'hF);
         check("rst_stalls",  {28'd0, bus.fetch_stall_out, bus.decode_stall_out,
                               bus.execute_stall_out, bus.mem_stall_out}, 32'h0);
         tick();
      end
      reset = 1'b0;
      @(negedge clk);
      check("idle_fetch_flush", {31'd0, bus.fetch_flush_out}, 32'd0);
      check("idle_count", bus.stall_count_out, 32'd0);
      tick();

      // Load x5 in execute, decode reads rs2=x5
      idle();
      bus.fetch_valid_in = 1'b1;  bus.execute_valid_in = 1'b1;
      bus.execute_mem_read_in = 1'b1; bus.execute_rd_write_in = 1'b1; bus.execute_rd_in = 5'd5;
      bus.decode_rs1_in = 5'd3; bus.decode_rs1_read_in = 1'b1;
      bus.decode_rs2_in = 5'd5; bus.decode_rs2_read_in = 1'b1;
      @(negedge clk);
      check("lu_fetch_stall",  {31'd0, bus.fetch_stall_out}, 32'd1);
      check("lu_decode_flush", {31'd0, bus.decode_flush_out}, 32'd1);
      tick();
      bus.execute_mem_read_in = 1'b0; bus.execute_rd_in = 5'd7; bus.mem_valid_in = 1'b1;
      @(negedge clk);
      check("lu_cleared", {31'd0, bus.fetch_stall_out}, 32'd0);
      check("lu_count", bus.stall_count_out, 32'd1);
      tick();
      // Load to x0 never stalls
      bus.execute_mem_read_in = 1'b1; bus.execute_rd_in = 5'd0; bus.decode_rs2_in = 5'd0;
      @(negedge clk);
      check("lu_x0", {31'd0, bus.fetch_stall_out}, 32'd0);
      tick();
      // Matching rs1 only counts when rs1 is actually read
      bus.execute_rd_in = 5'd4; bus.decode_rs1_in = 5'd4; bus.decode_rs1_read_in = 1'b0;
      bus.decode_rs2_in = 5'd9;
      @(negedge clk);
      check("lu_rs1_unread", {31'd0, bus.fetch_stall_out}, 32'd0);
      tick();
      bus.decode_rs1_read_in = 1'b1;
      @(negedge clk);
      check("lu_rs1_read", {31'd0, bus.fetch_stall_out}, 32'd1);
      tick();
      idle();
      tick();

      // FENCE with execute/memory occupied for 3 cycles: 4 stall cycles, then fence_out
      fence_in_decode(1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("fence_hold", {30'd0, bus.fetch_stall_out, bus.decode_flush_out}, 32'd3);
         tick();
      end
      bus.execute_valid_in = 1'b0; bus.mem_valid_in = 1'b0;
      @(negedge clk);
      check("fence_last_drain", {30'd0, bus.fetch_stall_out, bus.fence_out}, 32'd2);
      tick();
      @(negedge clk);
      check("fence_sync", {30'd0, bus.fetch_stall_out, bus.fence_out}, 32'd1);
      tick();
      bus.decode_mem_fence_in = 1'b0;
      @(negedge clk);
      check("fence_done", {30'd0, bus.fetch_stall_out, bus.fence_out}, 32'd0);
      check("fence_count", bus.stall_count_out, 32'd6);
      tick();

      // FENCE with empty pipeline: minimum cost of 2 stall cycles
      fence_in_decode(1'b0);
      tick(); tick();
      @(negedge clk);
      check("fence_min_pulse", {31'd0, bus.fence_out}, 32'd1);
      tick();
      bus.decode_mem_fence_in = 1'b0;
      @(negedge clk);
      check("fence_min_count", bus.stall_count_out, 32'd8);
      tick();

      // Taken branch during DRAIN aborts the FENCE
      fence_in_decode(1'b1);
      tick(); tick();
      bus.execute_branch_taken_in = 1'b1;
      @(negedge clk);
      check("br_drain", {29'd0, bus.fetch_flush_out, bus.decode_flush_out, bus.fetch_stall_out},
            32'd6);
      check("br_no_fence", {31'd0, bus.fence_out}, 32'd0);
      tick();
      idle(); bus.fetch_valid_in = 1'b1;
      @(negedge clk);
      check("br_back_run", {30'd0, bus.fetch_stall_out, bus.fence_out}, 32'd0);
      tick();
      @(negedge clk);
      check("br_still_no_fence", {31'd0, bus.fence_out}, 32'd0);
      check("br_count", bus.stall_count_out, 32'd10);
      tick();

      // Data wait for 5 cycles during DRAIN, together with a branch
      fence_in_decode(1'b1);
      tick(); tick();
      bus.data_wait_in = 1'b1; bus.execute_branch_taken_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("dw_stalls", {28'd0, bus.fetch_stall_out, bus.decode_stall_out,
                             bus.execute_stall_out, bus.mem_stall_out}, 32'hF);
         check("dw_flushes", {28'd0, bus.fetch_flush_out, bus.decode_flush_out,
                              bus.execute_flush_out, bus.mem_flush_out}, 32'h0);
         tick();
      end
      bus.data_wait_in = 1'b0;
      @(negedge clk);
      check("dw_branch_after", {29'd0, bus.fetch_flush_out, bus.decode_flush_out,
                                bus.fetch_stall_out}, 32'd6);
      tick();
      idle(); bus.fetch_valid_in = 1'b1;
      @(negedge clk);
      check("dw_back_run", {30'd0, bus.fetch_stall_out, bus.fence_out}, 32'd0);
      check("dw_count", bus.stall_count_out, 32'd17);
      tick();

      // Reset during DRAIN
      fence_in_decode(1'b1);
      tick(); tick();
      reset = 1'b1;
      @(negedge clk);
      check("rst_drain_flushes", {28'd0, bus.fetch_flush_out, bus.decode_flush_out,
                                  bus.execute_flush_out, bus.mem_flush_out}, 32'hF);
      tick();
      reset = 1'b0; bus.decode_mem_fence_in = 1'b0;
      @(negedge clk);
      check("rst_drain_run", {31'd0, bus.fetch_stall_out}, 32'd0);
      check("rst_drain_count", bus.stall_count_out, 32'd0);
      tick();

      // Instruction bus wait alone flushes fetch only
      idle(); bus.instr_wait_in = 1'b1;
      @(negedge clk);
      check("iw_flush", {29'd0, bus.fetch_flush_out, bus.decode_flush_out, bus.fetch_stall_out},
            32'd4);
      tick();

      // Counter wrap from 0xFFFFFFFF to 0
      idle();
      #1;
      force dut.stall_count_q = PRELOAD;
      preload_pending = 1'b1;
      #1;
      release dut.stall_count_q;
      fence_in_decode(1'b1);
      @(negedge clk);
      check("wrap_preload", bus.stall_count_out, PRELOAD);
      tick();
      preload_pending = 1'b0;
      @(negedge clk);
      check("wrap_max", bus.stall_count_out, 32'hFFFF_FFFF);
      tick();
      @(negedge clk);
      check("wrap_zero", bus.stall_count_out, 32'd0);
      tick();
      idle();
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
